// File: rtl/imem_loader.sv
// Instruction-memory program loader: byte stream in, big-endian words out.
// Holds the CPU in reset while a session is in progress.
module imem_loader #(
  parameter int NUM_BITS_ADDR_BARRAMENTO = 32,
  parameter int NUM_BITS_MEM_PROG        = 32,
  parameter int NUM_BITS_ADDR_PROG       = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [7:0]                          rx_data,
  input  logic                                rx_valid,
  output logic                                rx_ready,
  output logic                                wr_en,
  output logic [NUM_BITS_ADDR_BARRAMENTO-1:0] wr_addr,
  output logic [NUM_BITS_MEM_PROG-1:0]        wr_data,
  output logic                                cpu_hold,
  output logic                                done,
  output logic                                err
);

  localparam int IW = NUM_BITS_ADDR_PROG + 1;
  localparam logic [16:0] DEPTH = 17'(1 << NUM_BITS_ADDR_PROG);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, BYTES, WRITE, DONE, ERROR
  } state_t;

  state_t         state, state_n;
  logic [15:0]    len;
  logic [IW-1:0]  word_idx;
  logic [IW-1:0]  idx_next;
  logic [1:0]     byte_cnt;
  logic [15:0]    len_full;
  logic           xfer;

  assign rx_ready = (state == LEN_HI) || (state == LEN_LO) ||
                    (state == BYTES);
  assign wr_en    = (state == WRITE);
  assign cpu_hold = rx_ready || wr_en;
  assign done     = (state == DONE);
  assign err      = (state == ERROR);

  assign xfer     = rx_valid & rx_ready;
  assign len_full = {len[15:8], rx_data};
  assign idx_next = word_idx + 1'b1;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE, ERROR: if (start) state_n = LEN_HI;
      LEN_HI: if (xfer) state_n = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (len_full == 16'd0)
            state_n = DONE;
          else if ({1'b0, len_full} > DEPTH)
            state_n = ERROR;
          else
            state_n = BYTES;
        end
      end
      BYTES: if (xfer && byte_cnt == 2'd3) state_n = WRITE;
      WRITE: begin
        if (16'(idx_next) == len) state_n = DONE;
        else                      state_n = BYTES;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      len      <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      wr_data  <= '0;
      wr_addr  <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE, DONE, ERROR: if (start) word_idx <= '0;
        LEN_HI: if (xfer) len[15:8] <= rx_data;
        LEN_LO: begin
          if (xfer) begin
            len[7:0] <= rx_data;
            byte_cnt <= '0;
          end
        end
        BYTES: begin
          if (xfer) begin
            wr_data  <= {wr_data[NUM_BITS_MEM_PROG-9:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            // address is latched with the last byte so it is ready in WRITE
            if (byte_cnt == 2'd3)
              wr_addr <= NUM_BITS_ADDR_BARRAMENTO'(
                {word_idx[NUM_BITS_ADDR_PROG-1:0], 2'b00});
          end
        end
        WRITE: begin
          word_idx <= idx_next;
          byte_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a session-level model.
// Directed scenarios plus literal pins on the observed write log.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, wr_en, cpu_hold, done, err;
  logic [31:0] wr_addr, wr_data;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 0;
  int cyc = 0;

  // session model: header bytes, payload bytes, pending write, word count
  bit          m_busy, m_wpend, m_done, m_err;
  int          m_hdr, m_nb, m_words;
  int unsigned m_len;
  logic [31:0] m_addr, m_data;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_busy = 0; m_wpend = 0; m_done = 0; m_err = 0;
      m_hdr = 0; m_nb = 0; m_words = 0; m_len = 0;
      m_addr = 0; m_data = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_hdr = 0; m_done = 0; m_err = 0;
        m_words = 0; m_len = 0; m_nb = 0;
      end
    end else if (m_wpend) begin
      m_wpend = 0;
      m_words++;
      if (m_words == int'(m_len)) begin
        m_busy = 0; m_done = 1;
      end
    end else if (rx_valid) begin
      if (m_hdr < 2) begin
        m_len = (m_len << 8) | rx_data;
        m_hdr++;
        if (m_hdr == 2) begin
          m_nb = 0;
          if (m_len == 0) begin
            m_busy = 0; m_done = 1;
          end else if (m_len > 256) begin
            m_busy = 0; m_err = 1;
          end
        end
      end else begin
        m_data = {m_data[23:0], rx_data};
        m_nb++;
        if (m_nb == 4) begin
          m_wpend = 1;
          m_addr = 32'(m_words * 4);
          m_nb = 0;
        end
      end
    end
  end

  logic [68:0] act_v, exp_v;
  always @(negedge clk) begin
    if (armed) begin
      act_v = {rx_ready, wr_en, cpu_hold, done, err, wr_addr, wr_data};
      exp_v = {m_busy && !m_wpend, m_wpend, m_busy, m_done, m_err,
               m_addr, m_data};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL cycle%0d outputs: got rdy=%b we=%b hold=%b done=%b err=%b a=%h d=%h, exp rdy=%b we=%b hold=%b done=%b err=%b a=%h d=%h",
          cyc, rx_ready, wr_en, cpu_hold, done, err, wr_addr, wr_data,
          exp_v[68], exp_v[67], exp_v[66], exp_v[65], exp_v[64],
          exp_v[63:32], exp_v[31:0]);
      end
    end
  end

  logic [63:0] wlog[$];
  always @(negedge clk)
    if (armed && wr_en === 1'b1) wlog.push_back({wr_addr, wr_data});

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(logic [7:0] b, int maxgap);
    int gap, t;
    gap = (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0;
    repeat (gap) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      miscompares++;
      $display("FAIL send_timeout: rx_ready stuck at %b, expected 1", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(logic [31:0] w, int maxgap);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8], maxgap);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (cpu_hold !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      miscompares++;
      $display("FAIL idle_timeout: cpu_hold stuck at %b, expected 0", cpu_hold);
    end
    @(negedge clk);
  endtask

  task automatic run_test1(int maxgap, string tag);
    wlog.delete();
    pulse_start();
    send(8'h00, maxgap);
    send(8'h02, maxgap);
    send_word(32'h20080005, maxgap);
    send_word(32'hAC090000, maxgap);
    wait_idle();
    chk({tag, "_nwr"}, 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      chk({tag, "_w0"}, wlog[0], {32'h0, 32'h20080005});
      chk({tag, "_w1"}, wlog[1], {32'h4, 32'hAC090000});
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    armed = 1;
    chk("reset_state",
        {27'd0, rx_ready, wr_en, cpu_hold, done, err, wr_addr | wr_data},
        64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_test1(0, "t1");

    wlog.delete();
    pulse_start();
    send(8'h00, 0); send(8'h00, 0);
    wait_idle();
    chk("t2_nwr", 64'(wlog.size()), 64'd0);
    chk("t2_flags", {62'd0, done, err}, 64'b10);

    wlog.delete();
    pulse_start();
    send(8'h01, 0); send(8'h01, 0);
    wait_idle();
    chk("t3_flags", {61'd0, err, done, rx_ready}, 64'b100);
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    chk("t3_nwr", 64'(wlog.size()), 64'd0);
    pulse_start();
    send(8'h00, 0); send(8'h01, 0);
    send_word(32'hDEADBEEF, 0);
    wait_idle();
    chk("t3_recover", {62'd0, done, err}, 64'b10);
    chk("t3_w0", wlog.size() > 0 ? wlog[0] : 64'hX, {32'h0, 32'hDEADBEEF});

    wlog.delete();
    pulse_start();
    send(8'h01, 0); send(8'h00, 0);
    for (int i = 0; i < 256; i++) send_word($urandom, 0);
    wait_idle();
    chk("t4_nwr", 64'(wlog.size()), 64'd256);
    chk("t4_last", wlog.size() > 0 ? 64'(wlog[$][63:32]) : 64'hX, 64'h3FC);
    chk("t4_done", 64'(done), 64'd1);

    run_test1(3, "t5");

    wlog.delete();
    pulse_start();
    send(8'h00, 0); send(8'h02, 0);
    send(8'h11, 0); send(8'h22, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_reset",
        {27'd0, rx_ready, wr_en, cpu_hold, done, err, wr_addr | wr_data},
        64'd0);
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    send(8'h00, 0); send(8'h02, 0);
    send_word(32'h01234567, 0);
    pulse_start();
    send_word(32'h89ABCDEF, 1);
    wait_idle();
    chk("t6_nwr", 64'(wlog.size()), 64'd2);
    chk("t6_w0", wlog.size() > 0 ? wlog[0] : 64'hX, {32'h0, 32'h01234567});

    for (int s = 0; s < 8; s++) begin
      n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(257, 65535))
                                       : int'($urandom_range(0, 6));
      pulse_start();
      send(8'(n >> 8), 2);
      send(8'(n), 2);
      if (n <= 256)
        for (int i = 0; i < n; i++) send_word($urandom, 2);
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
